// File: rtl/counter_monitor.sv
// counter_monitor
// Passive checker and decoder for a 3-bit dual-mode (binary / Gray) counter.
// It samples count and mode every clock, predicts the legal successor,
// locks after LOCK_LEN consecutive good transitions and then flags any
// deviation with a one-cycle mismatch pulse and a saturating error count.
// Gray-mode samples are decoded back to binary on the value output.

module counter_monitor #(
    parameter int LOCK_LEN = 3,   // good transitions needed to lock, 1..7
    parameter int ERR_W    = 8    // width of the saturating error counter
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [2:0]       count,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       expected,
    output logic [2:0]       value
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // run is only 3 bits wide, so the lock target is taken modulo 8.
    localparam logic [2:0]       LOCK_TARGET = 3'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    // Next code in the Gray-up sequence 000,001,011,010,110,111,101,100.
    function automatic logic [2:0] gray_succ(input logic [2:0] g);
        logic [2:0] n;
        case (g)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b111;
            3'b111:  n = 3'b101;
            3'b101:  n = 3'b100;
            default: n = 3'b000;   // 3'b100 wraps to 000
        endcase
        return n;
    endfunction

    // Legal successor of a sample taken under a given mode.
    function automatic logic [2:0] succ(input logic [2:0] c, input logic m);
        return m ? gray_succ(c) : c + 3'd1;
    endfunction

    state_t           state_reg;
    logic [2:0]       last_count_reg;
    logic             last_mode_reg;
    logic [2:0]       run_reg;
    logic             locked_reg;
    logic             mismatch_reg;
    logic [ERR_W-1:0] err_count_reg;
    logic [2:0]       value_reg;

    logic [2:0]       count_bin;
    logic [2:0]       value_next;
    logic [2:0]       run_inc;
    logic [ERR_W-1:0] err_inc;
    logic             good;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_decode
            assign count_bin[gi] = ^count[2:gi];
        end
    endgenerate

    // The prediction uses the previously sampled mode: the counter derives its
    // next state from the mode seen at the same edge, so a mode change is
    // always legal and only affects the following transition.
    assign expected   = succ(last_count_reg, last_mode_reg);
    assign good       = (count == expected);
    assign value_next = mode ? count_bin : count;
    assign run_inc    = run_reg + 3'd1;
    assign err_inc    = (err_count_reg == ERR_MAX) ? ERR_MAX : err_count_reg + 1'b1;

    // Sampling registers, lock FSM, mismatch pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_count_reg <= 3'b000;
            last_mode_reg  <= 1'b0;
            run_reg        <= 3'd0;
            locked_reg     <= 1'b0;
            mismatch_reg   <= 1'b0;
            err_count_reg  <= '0;
            value_reg      <= 3'b000;
        end else begin
            last_count_reg <= count;
            last_mode_reg  <= mode;
            value_reg      <= value_next;
            mismatch_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // First sample after reset has no predecessor to check.
                    state_reg  <= ACQUIRE;
                    run_reg    <= 3'd0;
                    locked_reg <= 1'b0;
                end
                ACQUIRE: begin
                    // Errors while acquiring only restart the run; no pulse.
                    if (good) begin
                        if (run_inc == LOCK_TARGET) begin
                            state_reg  <= LOCKED;
                            run_reg    <= 3'd0;
                            locked_reg <= 1'b1;
                        end else begin
                            run_reg <= run_inc;
                        end
                    end else begin
                        run_reg <= 3'd0;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        mismatch_reg  <= 1'b1;
                        err_count_reg <= err_inc;
                        state_reg     <= ACQUIRE;
                        run_reg       <= 3'd0;
                        locked_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    run_reg    <= 3'd0;
                    locked_reg <= 1'b0;
                end
            endcase

            // A clear wins over a simultaneous increment.
            if (clr_err) begin
                err_count_reg <= '0;
            end
        end
    end

    assign locked    = locked_reg;
    assign mismatch  = mismatch_reg;
    assign err_count = err_count_reg;
    assign value     = value_reg;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor. Two instances share the stimulus:
// dut (ERR_W=8) and dut_s (ERR_W=2, used to see error-count saturation).
`timescale 1ns/1ps

module tb_counter_monitor;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [2:0] count;
    logic       clr_err;

    logic       locked,   locked_s;
    logic       mismatch, mismatch_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;
    logic [2:0] expected, expected_s;
    logic [2:0] value,    value_s;

    int tests_run = 0;
    int tests_failed = 0;

    counter_monitor #(.LOCK_LEN(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .count(count), .clr_err(clr_err),
        .locked(locked), .mismatch(mismatch), .err_count(err_count),
        .expected(expected), .value(value)
    );

    counter_monitor #(.LOCK_LEN(3), .ERR_W(2)) dut_s (
        .clk(clk), .reset(reset), .mode(mode), .count(count), .clr_err(clr_err),
        .locked(locked_s), .mismatch(mismatch_s), .err_count(err_count_s),
        .expected(expected_s), .value(value_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Present one sample, take the edge, settle 1 ns past it.
    task automatic cyc(input logic [2:0] c, input logic m);
        count = c;
        mode  = m;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] cur;
    logic [2:0] brk;

    initial begin
        reset   = 1'b1;
        mode    = 1'b0;
        count   = 3'b000;
        clr_err = 1'b0;

        // Reset state
        cyc(3'b000, 1'b0);
        chk("rst_locked",   int'(locked),    0);
        chk("rst_mismatch", int'(mismatch),  0);
        chk("rst_err",      int'(err_count), 0);
        chk("rst_value",    int'(value),     0);
        chk("rst_expected", int'(expected),  1);

        // 1: binary acquisition, lock on the edge carrying 011
        reset = 1'b0;
        cyc(3'b000, 1'b0); chk("bin0_locked", int'(locked), 0);
        cyc(3'b001, 1'b0); chk("bin1_value",  int'(value),  1);
        cyc(3'b010, 1'b0); chk("bin2_locked", int'(locked), 0);
        cyc(3'b011, 1'b0); chk("bin3_locked", int'(locked), 1);
        chk("bin3_value", int'(value), 3);
        cyc(3'b100, 1'b0);
        cyc(3'b101, 1'b0);
        cyc(3'b110, 1'b0);
        cyc(3'b111, 1'b0); chk("bin7_value", int'(value), 7);
        cyc(3'b000, 1'b0); chk("binwrap_mismatch", int'(mismatch), 0);
        chk("binwrap_locked", int'(locked), 1);
        chk("binwrap_expected", int'(expected), 1);
        chk("bin_err", int'(err_count), 0);

        // 3: switch to Gray while count = 011, next count 010 is legal
        cyc(3'b001, 1'b0);
        cyc(3'b010, 1'b0);
        cyc(3'b011, 1'b1);
        chk("sw_value",    int'(value),    2);
        chk("sw_expected", int'(expected), 2);
        cyc(3'b010, 1'b1);
        chk("sw_mismatch", int'(mismatch), 0);
        chk("sw_locked",   int'(locked),   1);
        chk("sw_value2",   int'(value),    3);
        cyc(3'b110, 1'b1); chk("g110_value", int'(value), 4);
        cyc(3'b111, 1'b1); chk("g111_value", int'(value), 5);
        cyc(3'b101, 1'b1); chk("g101_value", int'(value), 6);
        cyc(3'b100, 1'b1); chk("g100_value", int'(value), 7);
        cyc(3'b000, 1'b1); chk("gwrap_locked", int'(locked), 1);

        // 2: Gray run, then 000 injected instead of 111
        cyc(3'b001, 1'b1); chk("g_v1", int'(value), 1);
        cyc(3'b011, 1'b1); chk("g_v2", int'(value), 2);
        cyc(3'b010, 1'b1); chk("g_v3", int'(value), 3);
        cyc(3'b110, 1'b1); chk("g_v4", int'(value), 4);
        cyc(3'b000, 1'b1);
        chk("inj_mismatch", int'(mismatch), 1);
        chk("inj_err",      int'(err_count), 1);
        chk("inj_locked",   int'(locked),   0);
        cyc(3'b001, 1'b1); chk("inj_pulse_end", int'(mismatch), 0);
        cyc(3'b011, 1'b1); chk("reacq2_locked", int'(locked), 0);
        cyc(3'b010, 1'b1); chk("reacq3_locked", int'(locked), 1);
        chk("reacq_err", int'(err_count), 1);

        // 4: stuck count 101 while locked
        cyc(3'b110, 1'b1);
        cyc(3'b111, 1'b1);
        cyc(3'b101, 1'b1); chk("stk_pre_mismatch", int'(mismatch), 0);
        cyc(3'b101, 1'b1);
        chk("stk_mismatch", int'(mismatch),  1);
        chk("stk_err",      int'(err_count), 2);
        chk("stk_locked",   int'(locked),    0);
        cyc(3'b101, 1'b1);
        chk("stk_acq_mismatch", int'(mismatch),  0);
        chk("stk_acq_err",      int'(err_count), 2);

        // 6: relock, then one-cycle reset
        cyc(3'b100, 1'b1);
        cyc(3'b000, 1'b1);
        cyc(3'b001, 1'b1); chk("pre_rst_locked", int'(locked), 1);
        reset = 1'b1;
        cyc(3'b011, 1'b1);
        reset = 1'b0;
        chk("mrst_locked",   int'(locked),      0);
        chk("mrst_err",      int'(err_count),   0);
        chk("mrst_err_s",    int'(err_count_s), 0);
        chk("mrst_value",    int'(value),       0);
        chk("mrst_expected", int'(expected),    1);
        cyc(3'b000, 1'b0);
        cyc(3'b001, 1'b0);
        cyc(3'b010, 1'b0); chk("mrst_acq_locked", int'(locked), 0);
        cyc(3'b011, 1'b0); chk("mrst_relock",     int'(locked), 1);

        // 5: five lock/break cycles; narrow counter saturates at 3
        cur = 3'b011;
        for (int k = 0; k < 5; k++) begin
            brk = cur + 3'd2;
            cyc(brk, 1'b0);
            chk("brk_mismatch", int'(mismatch),    1);
            chk("brk_err",      int'(err_count),   k + 1);
            chk("brk_err_s",    int'(err_count_s), (k + 1 > 3) ? 3 : k + 1);
            cur = brk;
            for (int j = 0; j < 3; j++) begin
                cur = cur + 3'd1;
                cyc(cur, 1'b0);
            end
            chk("relock", int'(locked_s), 1);
        end
        clr_err = 1'b1;
        cyc(cur + 3'd2, 1'b0);
        clr_err = 1'b0;
        chk("clr_mismatch", int'(mismatch),    1);
        chk("clr_err",      int'(err_count),   0);
        chk("clr_err_s",    int'(err_count_s), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
